mem_fetch: RTL
==============

# mem_fetch

Sequential word fetcher that acts as the initiator on one read port of the 3-port, 2-cycle-latency `mem` block. It drives the port's word address, tracks in-flight reads against the memory's fixed latency, and delivers each returned word, tagged with its address, through a valid/ready output stream. It sits between `mem` and the decode stage and supports redirect, with discard of stale reads, and backpressure without loss.

## Interface

Parameters:
- `RESET_PC`, default `15'h0000`: word address fetched first after reset.
- `FIFO_DEPTH`, default `4`: output buffer entries. Must be a power of two and at least 4.

Ports:
- `clk` in, 1: clock.
- `rst_n` in, 1: reset. Asynchronous, active-low.
- `redirect` in, 1: discard all in-flight and buffered words, then restart at `redirect_pc`.
- `redirect_pc` in, [15:1]: new fetch word address.
- `raddr` out, [15:1]: word address to the `mem` read port.
- `rdata` in, [15:0]: data from the `mem` read port.
- `out_valid` out, 1: `out_pc`/`out_inst` hold a valid word.
- `out_ready` in, 1: consumer accepts the word.
- `out_pc` out, [15:1]: address of the presented word.
- `out_inst` out, [15:0]: presented word.

## Operation

- State:
  - `pc` register.
  - 2-stage in-flight shift pipeline; each stage holds {valid, addr}.
  - Output FIFO of {addr, data}.
- `raddr` is combinational and always equals `pc`.
- The memory reads continuously. Only cycles flagged as issue are tracked.
- Issue rule, in cycle t:
  - Issue when `!redirect` and (fifo_count + inflight_count) < FIFO_DEPTH.
  - Both counts are the registered values; a pop in the same cycle does not add credit.
- On issue:
  - Stage0 <= {1, `pc`}.
  - `pc` <= `pc` + 1, modulo 2^15, so `7FFF` wraps to `0000`.
- When not issuing, stage0 <= {0, x} and `pc` holds.
- Each clock, stage1 <= stage0.
- If stage1 is valid in cycle t+2, {stage1.addr, `rdata`} is pushed into the FIFO at the end of that cycle. Credit accounting guarantees the FIFO never overflows.
- `rdata` is ignored when stage1 is invalid.
- Output:
  - `out_valid` = FIFO not empty.
  - `out_pc`/`out_inst` = FIFO head.
  - A pop occurs when `out_valid && out_ready`.
  - Order equals issue order.
- Redirect, asserted in cycle t:
  - No issue in cycle t.
  - At the edge: `pc` <= `redirect_pc`, both stage valids cleared, FIFO emptied, and any push in that cycle suppressed.
  - A pop handshake in cycle t still completes; the consumer owns that word.
- A redirect asserted on consecutive cycles restarts from the last `redirect_pc`.
- Reset values, applied asynchronously:
  - `pc` = `RESET_PC`, so `raddr` = `RESET_PC`.
  - Stage valids = 0.
  - FIFO empty, so `out_valid` = 0.
  - `out_pc`/`out_inst` = 0.
- Reset asserted mid-stream drops everything. There is no partial-state retention.

## Timing

- Cycle 0 is the first cycle with `rst_n` high.
  - Issue of `RESET_PC` occurs in cycle 0.
  - `rdata` is valid in cycle 2.
  - `out_valid` is high in cycle 3.
- Issue-to-`out_valid` latency is 3 cycles.
- Steady state, with `out_ready` held high: one word per cycle, FIFO occupancy 1, credit 3 < 4.
- Redirect in cycle t: the issue of `redirect_pc` occurs in t+1, and the first new word has `out_valid` in t+4.
- Full FIFO plus 0 in-flight blocks issue. After the first pop, issue resumes the next cycle.
- The block makes no read-after-write ordering guarantee against the memory's write port. Coherence is the writer's concern.

## Structure

- Shared package `mem_pkg` holds:
  - `addr_t` (logic [15:1]).
  - `word_t` (logic [15:0]).
  - `MEM_RD_LATENCY = 2`.
- The in-flight pipeline depth derives from `MEM_RD_LATENCY`.
- One sub-module, `fetch_fifo`: synchronous FIFO with registered count, push/pop/flush, and pass-through-free head output. Parameterised by depth and width.
- Top level contains:
  - `pc`.
  - Credit logic.
  - In-flight pipeline.
  - Redirect handling.

## Test plan

Memory model is `mem` preloaded with data[a] = 16'h1000 + a.

- **Reset start-up:** release reset with `out_ready`=1.
  - `out_valid` rises in cycle 3 with `out_pc`=0000, `out_inst`=1000.
  - Then 0001/1001, 0002/1002, … every cycle with no gaps.
- **Backpressure:** hold `out_ready`=0 for 10 cycles from reset release.
  - Exactly 4 issues occur (`raddr` stops at 0004).
  - FIFO holds 0000–0003.
  - On release, the output stream is 0000, 0001, 0002, 0003, 0004… with no loss or duplicate.
- **Redirect with 2 in flight:** `redirect`=1, `redirect_pc`=1234 in cycle t.
  - No stale word appears.
  - Next `out_valid` is in t+4 with `out_pc`=1234, `out_inst`=2234.
- **Wrap:** `RESET_PC`=7FFE gives `out_pc` sequence 7FFE, 7FFF, 0000, 0001 with data 8FFE, 8FFF, 1000, 1001.
- **Simultaneous redirect and pop:** redirect in the same cycle as a pop handshake of word 0005.
  - 0005 is consumed once.
  - The next valid word is the redirect target.
  - No other old words appear.
- **Async reset mid-stream:** `rst_n` pulsed low between edges.
  - `out_valid` drops to 0 immediately.
  - After release, fetch restarts at `RESET_PC` with 3-cycle latency.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared address/data types and read-port timing of the mem block.
package mem_pkg;
    typedef logic [15:1] addr_t;
    typedef logic [15:0] word_t;

    localparam int MEM_RD_LATENCY = 2;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } stage_t;

    typedef struct packed {
        addr_t pc;
        word_t inst;
    } fetch_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with registered count, flush, and a head output
// driven only from storage (a word pushed this cycle is visible next cycle).
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = count == '0;
    assign do_push = push && !flush && count != FULL_C;
    assign do_pop  = pop && !empty;
    // Empty head reads as zero so the presented word is defined after reset and flush.
    assign dout    = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(do_push);
            rptr  <= rptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/mem_fetch.sv
// mem_fetch: sequential word fetcher on one mem read port; tracks in-flight reads
// against the fixed read latency and delivers {addr, data} on a valid/ready stream.
module mem_fetch
    import mem_pkg::*;
#(
    parameter addr_t RESET_PC   = 15'h0000,
    parameter int    FIFO_DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  redirect,
    input  addr_t redirect_pc,
    output addr_t raddr,
    input  word_t rdata,
    output logic  out_valid,
    input  logic  out_ready,
    output addr_t out_pc,
    output word_t out_inst
);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int          LAST    = MEM_RD_LATENCY - 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    addr_t         pc;
    stage_t        stage [MEM_RD_LATENCY];
    logic [CW-1:0] fifo_count, inflight;
    logic [CW:0]   credit;
    logic          issue, push, pop, empty;
    fetch_t        head, tail;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_RD_LATENCY; i++) inflight = inflight + CW'(stage[i].valid);
    end

    // Credit uses registered counts only: a same-cycle pop frees a slot one cycle later.
    assign credit    = {1'b0, fifo_count} + {1'b0, inflight};
    assign issue     = !redirect && credit < DEPTH_C;
    assign push      = stage[LAST].valid && !redirect;
    assign pop       = out_valid && out_ready;
    assign raddr     = pc;
    assign tail      = {stage[LAST].addr, rdata};
    assign out_valid = !empty;
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
            for (int i = 0; i < MEM_RD_LATENCY; i++) stage[i] <= '0;
        end else begin
            pc       <= redirect ? redirect_pc : issue ? pc + 15'd1 : pc;
            stage[0] <= '{valid: issue, addr: pc};
            for (int i = 1; i < MEM_RD_LATENCY; i++) stage[i] <= redirect ? '0 : stage[i-1];
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH($bits(fetch_t))
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(redirect),
        .push (push),
        .pop  (pop),
        .din  (tail),
        .dout (head),
        .empty(empty),
        .count(fifo_count)
    );
endmodule
